// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the clock/reset housekeeping block.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK   = 2'd0,
        ST_LOCK_FILTER = 2'd1,
        ST_RST_HOLD    = 2'd2,
        ST_RUN         = 2'd3
    } state_e;

    // Counter width able to hold the larger of two hold times.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_rst_ctrl_ce_div.sv
// Single-channel clock-enable divider, restarted on RUN entry or align.
module ce_div
    import clk_rst_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run_i,
    input  logic             active_i,
    input  logic             align_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             ce_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] nat;
    logic [DIV_W-1:0] last;
    logic             ce_q;
    logic             ce_d;

    always_comb begin
        last  = div_i - DIV_W'(1);
        nat   = (div_q == last) ? '0 : div_q + DIV_W'(1);
        div_d = nat;
        if (!run_i || !active_i || align_i) begin
            div_d = '0;
        end
        // A pulse due on the align edge is still issued.
        ce_d = run_i && ((div_d == last) ||
                         (active_i && align_i && nat == last));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            ce_q  <= ce_d;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/clk_rst_ctrl.sv
// Lock synchroniser/filter, reset sequencer, clock-enable strobes
// and loss-of-lock counter for the PLL clock domain.
module clk_rst_ctrl
    import clk_rst_pkg::*;
#(
    parameter int                     NUM_CE    = 2,
    parameter int                     DIV_W     = 8,
    parameter logic [NUM_CE*DIV_W-1:0] CE_DIVS  = {8'd16, 8'd2},
    parameter int                     LOCK_HOLD = 1024,
    parameter int                     RST_HOLD  = 16,
    parameter int                     LOSS_W    = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pll_locked,
    input  logic              ce_align,
    output logic              rst_out_n,
    output logic              ready,
    output logic [NUM_CE-1:0] ce,
    output logic [LOSS_W-1:0] loss_count
);

    localparam int CNT_W = cnt_width(LOCK_HOLD, RST_HOLD);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              sync1_q;
    logic              lock_s;
    logic              run_q;
    logic [LOSS_W-1:0] loss_q;
    logic [LOSS_W-1:0] loss_d;
    logic              run_d;
    logic              active;

    // Two-flop synchroniser; the only consumer of raw pll_locked.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            lock_s  <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_LOCK_FILTER;
                    cnt_d   = '0;
                end
            end
            ST_LOCK_FILTER: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_HOLD - 1)) begin
                    state_d = ST_RST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        loss_d = loss_q;
        if (state_q == ST_RUN && !lock_s && loss_q != '1) begin
            loss_d = loss_q + LOSS_W'(1);
        end
    end

    assign run_d  = (state_d == ST_RUN);
    assign active = (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            loss_q  <= loss_d;
        end
    end

    assign rst_out_n  = run_q;
    assign ready      = run_q;
    assign loss_count = loss_q;

    for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
        if (CE_DIVS[i*DIV_W +: DIV_W] == '0) begin : g_bad
            $error("clk_rst_ctrl: CE_DIVS entry must be non-zero");
        end
        ce_div #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk     (clk),
            .resetn  (resetn),
            .run_i   (run_d),
            .active_i(active),
            .align_i (ce_align),
            .div_i   (CE_DIVS[i*DIV_W +: DIV_W]),
            .ce_o    (ce[i])
        );
    end

endmodule
